rs_gf_div_seq: RTL and testbench

Sequential GF(2^m) divider: computes odat = a / b = a · b^(2^m−2) by iterative square-and-multiply over m−1 clock-enabled cycles. It is the inverse of the constant-operand GF multiplier. Chien/Forney stages use it where a runtime divisor is needed, for example error magnitude = Ω(X⁻¹)/Λ'(X⁻¹). One operation is in flight at a time, with a ready/valid-style handshake.

---
 rtl/rs_gf_div_seq.sv | 130 +++++++++++++
 tb/tb_rs_gf_div_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rs_gf_div_seq.sv
// Sequential GF(2^m) divider: odat = a * b^(2^m-2) via m-1 square-and-multiply steps.
// Optional divide-by-zero flag enabled by defining RS_GF_DIV_ZERO_CHECK_EN.
module rs_gf_div_seq #(
  parameter int m      = 8,
  parameter int irrpol = 285
) (
  input  logic         iclk,
  input  logic         ireset,
  input  logic         iclkena,
  input  logic         ival,
  input  logic [m-1:0] idat_a,
  input  logic [m-1:0] idat_b,
  output logic         obusy,
  output logic         oval,
  output logic [m-1:0] odat,
  output logic         oerr
);

  localparam int CW = $clog2(m);
  localparam logic [m-1:0] POLY = m'(irrpol);

  typedef enum logic {IDLE, RUN} state_t;

  // MSB-first shift-and-add multiply, reducing by the low m bits of irrpol
  function automatic logic [m-1:0] gf_mul(input logic [m-1:0] x, input logic [m-1:0] y);
    logic [m-1:0] r;
    r = '0;
    for (int i = m-1; i >= 0; i--) begin
      r = {r[m-2:0], 1'b0} ^ (r[m-1] ? POLY : '0);
      if (y[i]) r = r ^ x;
    end
    return r;
  endfunction

  state_t         state_q, state_d;
  logic [m-1:0]   acc_q, acc_d;
  logic [m-1:0]   sq_q, sq_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [m-1:0]   odat_q, odat_d;
  logic           oval_q, oval_d;
  logic [m-1:0]   prod_acc, prod_sq, b_sq;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
  logic           zero_q, zero_d;
  logic           oerr_q, oerr_d;
`endif

  assign prod_acc = gf_mul(acc_q, sq_q);
  assign prod_sq  = gf_mul(sq_q, sq_q);
  assign b_sq     = gf_mul(idat_b, idat_b);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sq_d    = sq_q;
    cnt_d   = cnt_q;
    odat_d  = odat_q;
    oval_d  = 1'b0;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
    zero_d  = zero_q;
    oerr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ival) begin
          acc_d   = idat_a;
          sq_d    = b_sq;
          cnt_d   = CW'(m-2);
          state_d = RUN;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
          zero_d  = ~|idat_b;
`endif
        end
      end
      RUN: begin
        acc_d = prod_acc;
        sq_d  = prod_sq;
        if (cnt_q == '0) begin
          // prod_acc already includes the final b^(2^(m-1)) factor
          oval_d  = 1'b1;
          state_d = IDLE;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
          odat_d  = zero_q ? '0 : prod_acc;
          oerr_d  = zero_q;
`else
          odat_d  = prod_acc;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sq_q    <= '0;
      cnt_q   <= '0;
      odat_q  <= '0;
      oval_q  <= 1'b0;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
      zero_q  <= 1'b0;
      oerr_q  <= 1'b0;
`endif
    end else if (iclkena) begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sq_q    <= sq_d;
      cnt_q   <= cnt_d;
      odat_q  <= odat_d;
      oval_q  <= oval_d;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
      zero_q  <= zero_d;
      oerr_q  <= oerr_d;
`endif
    end
  end

  assign obusy = (state_q == RUN);
  assign oval  = oval_q;
  assign odat  = odat_q;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
  assign oerr  = oerr_q;
`else
  assign oerr  = 1'b0;
`endif

endmodule

// File: tb/tb_rs_gf_div_seq.sv
// Bench for rs_gf_div_seq (m=8, irrpol=285): cycle model of handshake/latency plus
// quotient from a brute-force inverse table, with literal checks pinning the model.
module tb_rs_gf_div_seq;

  localparam int M = 8;
`ifdef RS_GF_DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic         iclk = 1'b0;
  logic         ireset, iclkena, ival;
  logic [M-1:0] idat_a, idat_b;
  logic         obusy, oval, oerr;
  logic [M-1:0] odat;

  int checks = 0;
  int errors = 0;
  logic [7:0] inv [256];

  rs_gf_div_seq #(.m(M), .irrpol(285)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival),
    .idat_a(idat_a), .idat_b(idat_b),
    .obusy(obusy), .oval(oval), .odat(odat), .oerr(oerr)
  );

  always #5 iclk = ~iclk;

  // Schoolbook polynomial product followed by long-division reduction
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    logic [15:0] poly;
    p = '0;
    poly = 16'(285);
    for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (16'(x) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (poly << (i-8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] quot(input logic [7:0] a, input logic [7:0] b);
    return (b == 8'h00) ? 8'h00 : gmul(a, inv[b]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model + per-cycle compare
  initial begin
    logic r, en, v, accept;
    logic [7:0] a, b, ma, mb, eodat;
    logic mbusy, eoval, eoerr;
    int mrem;
    mbusy = 0; eoval = 0; eoerr = 0; eodat = 0; mrem = 0; ma = 0; mb = 0;
    forever begin
      @(posedge iclk);
      r = ireset; en = iclkena; v = ival; a = idat_a; b = idat_b;
      if (r) begin
        mbusy = 0; mrem = 0; eoval = 0; eoerr = 0; eodat = 0;
      end else if (en) begin
        accept = v && !mbusy;
        eoval = 0; eoerr = 0;
        if (mbusy) begin
          mrem--;
          if (mrem == 0) begin
            mbusy = 0; eoval = 1;
            eodat = quot(ma, mb);
            eoerr = ZC && (mb == 8'h00);
          end
        end
        if (accept) begin
          ma = a; mb = b; mbusy = 1; mrem = M - 1;
        end
      end
      #1;
      chk("obusy", obusy, mbusy);
      chk("oval", oval, eoval);
      chk("odat", odat, eodat);
      chk("oerr", oerr, eoerr);
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic e, output int lat);
    @(negedge iclk);
    ival = 1; idat_a = a; idat_b = b;
    @(negedge iclk);
    ival = 0; idat_a = 8'($urandom); idat_b = 8'($urandom);
    lat = 1;
    while (!oval && lat < 40) begin
      @(negedge iclk);
      idat_a = 8'($urandom); idat_b = 8'($urandom);
      lat++;
    end
    q = odat; e = oerr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q;
    logic e;
    int lat, bad;
    logic [7:0] da [5];
    logic [7:0] db [5];
    logic [7:0] dq [5];
    da = '{8'h01, 8'h53, 8'h57, 8'hA5, 8'h00};
    db = '{8'h02, 8'h01, 8'h57, 8'h00, 8'h37};
    dq = '{8'h8E, 8'h53, 8'h01, 8'h00, 8'h00};

    ireset = 1; iclkena = 1; ival = 0; idat_a = 0; idat_b = 0;

    inv[0] = 8'h00;
    for (int bb = 1; bb < 256; bb++) begin
      inv[bb] = 8'h00;
      for (int x = 1; x < 256; x++) if (gmul(8'(bb), 8'(x)) == 8'h01) inv[bb] = 8'(x);
    end
    chk("model_inv2", inv[2], 8'h8E);
    bad = 0;
    for (int aa = 1; aa < 256; aa++)
      for (int bb = 1; bb < 256; bb++)
        if (gmul(quot(8'(aa), 8'(bb)), 8'(bb)) != 8'(aa)) bad++;
    chk("model_identity", bad, 0);

    repeat (3) @(negedge iclk);
    ireset = 0;

    // Directed operands with literal quotients and latency
    for (int i = 0; i < 5; i++) begin
      do_op(da[i], db[i], q, e, lat);
      chk("lit_lat", lat, 8);
      chk("lit_odat", q, dq[i]);
      chk("lit_oerr", e, (ZC && db[i] == 8'h00) ? 1 : 0);
    end

    // Random nonzero pairs, one at a time
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(1, 255)); rb = 8'($urandom_range(1, 255));
      do_op(ra, rb, q, e, lat);
      chk("rnd_identity", gmul(q, rb), ra);
    end

    // ival held high with operands changing every cycle
    for (int i = 0; i < 120; i++) begin
      @(negedge iclk);
      ival = 1; idat_a = 8'($urandom);
      idat_b = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
    end

    // Random clock-enable stalls
    for (int i = 0; i < 600; i++) begin
      @(negedge iclk);
      iclkena = ($urandom % 10) < 7;
      ival = 1'($urandom); idat_a = 8'($urandom);
      idat_b = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
    end
    @(negedge iclk);
    iclkena = 1; ival = 0;
    repeat (12) @(negedge iclk);

    // Reset in the middle of a run
    ival = 1; idat_a = 8'h1C; idat_b = 8'h09;
    @(negedge iclk);
    ival = 0;
    repeat (3) @(negedge iclk);
    ireset = 1;
    @(negedge iclk);
    ireset = 0;
    chk("rst_obusy", obusy, 0);
    chk("rst_oval", oval, 0);
    chk("rst_odat", odat, 0);
    repeat (10) @(negedge iclk);
    do_op(8'h1C, 8'h09, q, e, lat);
    chk("post_rst_lat", lat, 8);
    chk("post_rst_identity", gmul(q, 8'h09), 8'h1C);

    repeat (3) @(negedge iclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
